// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0) SPI initiator: one start pulse runs one full-duplex DATA_W-bit frame.
// Optional macro SPI_MASTER_LSB_FIRST_EN switches both directions to LSB first (default MSB first).
module spi_master #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              spi_clk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BITS_DONE  = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] FINAL_FALL = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [BIT_W-1:0]  r_bits, w_bits_next;
  logic [DATA_W-1:0] r_tx, w_tx_next;
  logic [DATA_W-1:0] r_rx, w_rx_next;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_next;
  logic              r_sclk, w_sclk_next;
  logic              r_cs, w_cs_next;
  logic              r_mosi, w_mosi_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;

  logic              w_tick;
  logic              w_first_bit;
  logic              w_next_bit;
  logic [DATA_W-1:0] w_tx_shifted;
  logic [DATA_W-1:0] w_rx_shifted;

  assign w_tick = (r_cnt == CNT_LAST);

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_first_bit  = tx_data[0];
  assign w_next_bit   = r_tx[1];
  assign w_tx_shifted = r_tx >> 1;
  assign w_rx_shifted = {miso, r_rx[DATA_W-1:1]};
`else
  assign w_first_bit  = tx_data[DATA_W-1];
  assign w_next_bit   = r_tx[DATA_W-2];
  assign w_tx_shifted = r_tx << 1;
  assign w_rx_shifted = {r_rx[DATA_W-2:0], miso};
`endif

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = w_tick ? '0 : r_cnt + 1'b1;
    w_bits_next    = r_bits;
    w_tx_next      = r_tx;
    w_rx_next      = r_rx;
    w_rx_data_next = r_rx_data;
    w_sclk_next    = r_sclk;
    w_cs_next      = r_cs;
    w_mosi_next    = r_mosi;
    w_done_next    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (start) begin
          w_state_next = SHIFT;
          w_tx_next    = tx_data;
          w_rx_next    = '0;
          w_bits_next  = '0;
          w_cs_next    = 1'b0;
          w_mosi_next  = w_first_bit;
        end
      end
      SHIFT: begin
        if (w_tick) begin
          // r_bits counts completed falling edges; once all are done the
          // next tick closes the frame instead of toggling spi_clk.
          if (r_bits == BITS_DONE) begin
            w_state_next   = GAP;
            w_cs_next      = 1'b1;
            w_mosi_next    = 1'b0;
            w_rx_data_next = r_rx;
            w_done_next    = 1'b1;
          end else if (!r_sclk) begin
            w_sclk_next = 1'b1;
            w_rx_next   = w_rx_shifted;
          end else begin
            w_sclk_next = 1'b0;
            w_bits_next = r_bits + 1'b1;
            if (r_bits != FINAL_FALL) begin
              w_tx_next   = w_tx_shifted;
              w_mosi_next = w_next_bit;
            end
          end
        end
      end
      GAP: begin
        if (w_tick) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    w_busy_next = (w_state_next != IDLE);
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_bits    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_sclk    <= 1'b0;
      r_cs      <= 1'b1;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_bits    <= w_bits_next;
      r_tx      <= w_tx_next;
      r_rx      <= w_rx_next;
      r_rx_data <= w_rx_data_next;
      r_sclk    <= w_sclk_next;
      r_cs      <= w_cs_next;
      r_mosi    <= w_mosi_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign spi_clk = r_sclk;
  assign cs      = r_cs;
  assign mosi    = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default instance (16 bits, div 1) and a slow instance (8 bits, div 3).
module tb_spi_master;

`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst;
  logic        start_a, busy_a, done_a, sclk_a, cs_a, mosi_a, miso_a;
  logic [15:0] tx_a, rx_a;
  logic        start_b, busy_b, done_b, sclk_b, cs_b, mosi_b, miso_b;
  logic [7:0]  tx_b, rx_b;

  int errors = 0;
  int checks = 0;

  spi_master #(.DATA_W(16), .CLK_DIV(1)) dut_a (
    .sys_clk(sys_clk), .rst(rst), .start(start_a), .tx_data(tx_a),
    .busy(busy_a), .done(done_a), .rx_data(rx_a), .spi_clk(sclk_a),
    .cs(cs_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_master #(.DATA_W(8), .CLK_DIV(3)) dut_b (
    .sys_clk(sys_clk), .rst(rst), .start(start_b), .tx_data(tx_b),
    .busy(busy_b), .done(done_b), .rx_data(rx_b), .spi_clk(sclk_b),
    .cs(cs_b), .mosi(mosi_b), .miso(miso_b)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; tx_a = '0; tx_b = '0;
    miso_a = 1'b0; miso_b = 1'b0;
    tick(); tick();
    checks++; if (cs_a !== 1'b1)    begin errors++; $display("FAIL reset_cs got=%b want=1", cs_a); end
    checks++; if (sclk_a !== 1'b0)  begin errors++; $display("FAIL reset_sclk got=%b want=0", sclk_a); end
    checks++; if (mosi_a !== 1'b0)  begin errors++; $display("FAIL reset_mosi got=%b want=0", mosi_a); end
    checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b want=0", done_a); end
    checks++; if (rx_a !== 16'h0)   begin errors++; $display("FAIL reset_rx got=%h want=0000", rx_a); end
    checks++; if (cs_b !== 1'b1 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_b cs=%b busy=%b want 1/0", cs_b, busy_b); end
    rst = 1'b1;
    tick();
    checks++; if (cs_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL reset_release cs=%b busy=%b want 1/0", cs_a, busy_a); end
    $display("test_reset done");
  endtask

  task automatic test_reset_mid_frame();
    int done_cnt;
    done_cnt = 0;
    tx_a = 16'hFFFF; miso_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    rst = 1'b0;
    #1;
    checks++; if (cs_a !== 1'b1 || sclk_a !== 1'b0 || busy_a !== 1'b0 || mosi_a !== 1'b0)
      begin errors++; $display("FAIL midreset_outputs cs=%b sclk=%b busy=%b mosi=%b want 1/0/0/0", cs_a, sclk_a, busy_a, mosi_a); end
    tick();
    rst = 1'b1; miso_a = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done_a === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL midreset_done got=%0d pulses want=0", done_cnt); end
    checks++; if (rx_a !== 16'h0) begin errors++; $display("FAIL midreset_rx got=%h want=0000", rx_a); end
    $display("test_reset_mid_frame done");
  endtask

  // tp is the miso bit pattern in wire order (bit 15 first).
  task automatic frame_a(input logic [15:0] tx, input logic [15:0] tp, input logic [15:0] exp_mosi,
                         input logic [15:0] exp_rx, input int glitch_cyc, input string name);
    int cyc, rises, done_cnt, done_cyc, busy_low_cyc, bad_mosi, idx;
    logic [15:0] stream;
    logic prev_sclk, prev_mosi;
    rises = 0; done_cnt = 0; done_cyc = -1; busy_low_cyc = -1; bad_mosi = 0; idx = 0; stream = '0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL %s idle_busy got=%b want=0", name, busy_a); end
    tx_a = tx; start_a = 1'b1; miso_a = tp[15];
    tick();
    cyc = 1; start_a = 1'b0; tx_a = ~tx;
    checks++; if (cs_a !== 1'b0 || busy_a !== 1'b1 || mosi_a !== exp_mosi[15])
      begin errors++; $display("FAIL %s cycle1 cs=%b busy=%b mosi=%b want 0/1/%b", name, cs_a, busy_a, mosi_a, exp_mosi[15]); end
    prev_sclk = sclk_a; prev_mosi = mosi_a;
    for (int n = 0; n < 100; n++) begin
      if (cyc == glitch_cyc) begin start_a = 1'b1; tx_a = 16'hFFFF; end
      else start_a = 1'b0;
      tick();
      cyc++;
      if (sclk_a === 1'b1 && prev_sclk === 1'b0) begin rises++; stream = {stream[14:0], mosi_a}; end
      if (sclk_a === 1'b0 && prev_sclk === 1'b1) begin idx++; miso_a = (idx < 16) ? tp[15-idx] : 1'b0; end
      if (mosi_a !== prev_mosi && sclk_a !== 1'b0) bad_mosi++;
      if (done_a === 1'b1) begin done_cnt++; done_cyc = cyc; end
      prev_sclk = sclk_a; prev_mosi = mosi_a;
      if (busy_a === 1'b0) begin busy_low_cyc = cyc; break; end
    end
    start_a = 1'b0;
    checks++; if (stream !== exp_mosi) begin errors++; $display("FAIL %s mosi_stream got=%h want=%h", name, stream, exp_mosi); end
    checks++; if (rises != 16)         begin errors++; $display("FAIL %s sclk_rises got=%0d want=16", name, rises); end
    checks++; if (done_cyc != 34)      begin errors++; $display("FAIL %s done_cycle got=%0d want=34", name, done_cyc); end
    checks++; if (done_cnt != 1)       begin errors++; $display("FAIL %s done_pulses got=%0d want=1", name, done_cnt); end
    checks++; if (busy_low_cyc != 35)  begin errors++; $display("FAIL %s busy_low_cycle got=%0d want=35", name, busy_low_cyc); end
    checks++; if (rx_a !== exp_rx)     begin errors++; $display("FAIL %s rx_data got=%h want=%h", name, rx_a, exp_rx); end
    checks++; if (bad_mosi != 0)       begin errors++; $display("FAIL %s mosi_while_sclk_high got=%0d want=0", name, bad_mosi); end
    tick(); tick(); tick();
    checks++; if (cs_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL %s stays_idle cs=%b busy=%b want 1/0", name, cs_a, busy_a); end
    $display("%s: tx=%h mosi=%h rx=%h done_cyc=%0d", name, tx, stream, rx_a, done_cyc);
  endtask

  task automatic test_single_frame();
    frame_a(16'hA5C3, LSB ? rev16(16'h3C5A) : 16'h3C5A, LSB ? rev16(16'hA5C3) : 16'hA5C3,
            16'h3C5A, -1, "single_frame");
  endtask

  task automatic test_bit_order();
    // miso pattern on the wire: a 1 followed by fifteen 0s
    frame_a(16'h0001, 16'h8000, LSB ? 16'h8000 : 16'h0001, LSB ? 16'h0001 : 16'h8000, -1, "bit_order");
  endtask

  task automatic test_ignored_start();
    frame_a(16'h0001, 16'h6B2D, LSB ? 16'h8000 : 16'h0001, LSB ? rev16(16'h6B2D) : 16'h6B2D, 5, "ignored_start");
  endtask

  task automatic test_back_to_back();
    logic [31:0] tp, stream, exp_stream;
    logic [15:0] exp_rx;
    int cyc, rises, done_cnt, d1, d2, cs_hi, idx;
    logic prev_sclk, drop_armed;
    tp = 32'hC3A5_0F96;
    exp_rx = LSB ? rev16(16'h0F96) : 16'h0F96;
    exp_stream = LSB ? {rev16(16'h1234), rev16(16'h5678)} : 32'h1234_5678;
    rises = 0; done_cnt = 0; d1 = -1; d2 = -1; cs_hi = 0; idx = 0; stream = '0; drop_armed = 1'b0;
    tx_a = 16'h1234; start_a = 1'b1; miso_a = tp[31];
    tick();
    cyc = 1; tx_a = 16'h5678;
    prev_sclk = sclk_a;
    for (int n = 0; n < 150; n++) begin
      tick();
      cyc++;
      if (sclk_a === 1'b1 && prev_sclk === 1'b0) begin rises++; stream = {stream[30:0], mosi_a}; end
      if (sclk_a === 1'b0 && prev_sclk === 1'b1) begin idx++; miso_a = (idx < 32) ? tp[31-idx] : 1'b0; end
      if (done_a === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) d1 = cyc; else d2 = cyc;
      end
      if (done_cnt == 1 && cs_a === 1'b1) cs_hi++;
      prev_sclk = sclk_a;
      if (drop_armed) start_a = 1'b0;
      if (busy_a === 1'b0 && done_cnt == 1) drop_armed = 1'b1;
      if (busy_a === 1'b0 && done_cnt >= 2) break;
    end
    start_a = 1'b0;
    checks++; if (done_cnt != 2)       begin errors++; $display("FAIL b2b done_pulses got=%0d want=2", done_cnt); end
    checks++; if (d2 - d1 != 35)       begin errors++; $display("FAIL b2b done_spacing got=%0d want=35", d2 - d1); end
    checks++; if (cs_hi != 2)          begin errors++; $display("FAIL b2b cs_high_cycles got=%0d want=2", cs_hi); end
    checks++; if (rises != 32)         begin errors++; $display("FAIL b2b sclk_rises got=%0d want=32", rises); end
    checks++; if (stream !== exp_stream) begin errors++; $display("FAIL b2b mosi_stream got=%h want=%h", stream, exp_stream); end
    checks++; if (rx_a !== exp_rx)     begin errors++; $display("FAIL b2b rx_data got=%h want=%h", rx_a, exp_rx); end
    $display("back_to_back: mosi=%h rx=%h done at %0d and %0d", stream, rx_a, d1, d2);
  endtask

  task automatic test_slow_clock();
    logic [7:0] tp, stream;
    int cyc, rises, r1, r2, done_cyc, busy_low_cyc, bad_mosi, idx;
    logic prev_sclk, prev_mosi;
    tp = 8'hA5;
    rises = 0; r1 = -1; r2 = -1; done_cyc = -1; busy_low_cyc = -1; bad_mosi = 0; idx = 0; stream = '0;
    tx_b = 8'h81; start_b = 1'b1; miso_b = tp[7];
    tick();
    cyc = 1; start_b = 1'b0; tx_b = 8'h00;
    prev_sclk = sclk_b; prev_mosi = mosi_b;
    for (int n = 0; n < 200; n++) begin
      tick();
      cyc++;
      if (sclk_b === 1'b1 && prev_sclk === 1'b0) begin
        rises++; stream = {stream[6:0], mosi_b};
        if (rises == 1) r1 = cyc;
        if (rises == 2) r2 = cyc;
      end
      if (sclk_b === 1'b0 && prev_sclk === 1'b1) begin idx++; miso_b = (idx < 8) ? tp[7-idx] : 1'b0; end
      if (mosi_b !== prev_mosi && sclk_b !== 1'b0) bad_mosi++;
      if (done_b === 1'b1) done_cyc = cyc;
      prev_sclk = sclk_b; prev_mosi = mosi_b;
      if (busy_b === 1'b0) begin busy_low_cyc = cyc; break; end
    end
    checks++; if (r1 != 4)             begin errors++; $display("FAIL slow first_rise got=%0d want=4", r1); end
    checks++; if (r2 - r1 != 6)        begin errors++; $display("FAIL slow sclk_period got=%0d want=6", r2 - r1); end
    checks++; if (done_cyc != 52)      begin errors++; $display("FAIL slow done_cycle got=%0d want=52", done_cyc); end
    checks++; if (busy_low_cyc != 55)  begin errors++; $display("FAIL slow busy_low_cycle got=%0d want=55", busy_low_cyc); end
    checks++; if (rises != 8)          begin errors++; $display("FAIL slow sclk_rises got=%0d want=8", rises); end
    checks++; if (stream !== 8'h81)    begin errors++; $display("FAIL slow mosi_stream got=%h want=81", stream); end
    checks++; if (rx_b !== 8'hA5)      begin errors++; $display("FAIL slow rx_data got=%h want=a5", rx_b); end
    checks++; if (bad_mosi != 0)       begin errors++; $display("FAIL slow mosi_while_sclk_high got=%0d want=0", bad_mosi); end
    $display("slow_clock: mosi=%h rx=%h done_cyc=%0d", stream, rx_b, done_cyc);
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_single_frame();
    test_bit_order();
    test_ignored_start();
    test_back_to_back();
    test_slow_clock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
